// File: rtl/spi_master_byte_if.sv
// Byte handshake between the CPU-side SPI control registers and the SPI byte engine.
// The master modport is the register side; the slave modport is the engine.
interface spi_master_byte_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master_byte.sv
// Byte-level SPI mode-0 master: shifts each accepted byte out MSB-first while
// assembling the returned byte; chip select may be held low across bytes.
module spi_master_byte #(
  parameter int DIV_W = 8
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] prescale,
  input  logic             cs_hold,
  output logic             busy,
  output logic             spi_sck,
  output logic             spi_csb,
  output logic             spi_sdo,
  output logic             spi_sdoenb,
  input  logic             spi_sdi,
  spi_master_byte_if.slave host
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, END} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, p_lat, p_lat_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [6:0]       tx_sh, tx_sh_n;
  logic [7:0]       rx_sh, rx_sh_n, rx_data_q, rx_data_n;
  logic             rx_valid_q, rx_valid_n;
  logic             sck_q, sck_n, csb_q, csb_n, sdo_q, sdo_n;
  logic             tx_ready, accept, cnt_done;

  assign tx_ready = enable && (state == IDLE || state == HOLD);
  assign accept   = host.tx_valid && tx_ready;
  assign cnt_done = (cnt == '0);

  assign host.tx_ready = tx_ready;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
  assign busy          = (state != IDLE);
  assign spi_sck       = sck_q;
  assign spi_csb       = csb_q;
  assign spi_sdo       = sdo_q;
  assign spi_sdoenb    = csb_q;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      p_lat      <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      csb_q      <= 1'b1;
      sdo_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      p_lat      <= p_lat_n;
      bit_cnt    <= bit_cnt_n;
      tx_sh      <= tx_sh_n;
      rx_sh      <= rx_sh_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      sck_q      <= sck_n;
      csb_q      <= csb_n;
      sdo_q      <= sdo_n;
    end
  end

  // Every timed state runs P = p_lat+1 cycles; bit_cnt counts completed falling edges.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    p_lat_n    = p_lat;
    bit_cnt_n  = bit_cnt;
    tx_sh_n    = tx_sh;
    rx_sh_n    = rx_sh;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    sck_n      = sck_q;
    csb_n      = csb_q;
    sdo_n      = sdo_q;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          state_n   = SETUP;
          cnt_n     = prescale;
          p_lat_n   = prescale;
          bit_cnt_n = '0;
          tx_sh_n   = host.tx_data[6:0];
          rx_sh_n   = '0;
          csb_n     = 1'b0;
          sck_n     = 1'b0;
          sdo_n     = host.tx_data[7];
        end else if (state == HOLD && (!cs_hold || !enable)) begin
          state_n = END;
          cnt_n   = p_lat;
          csb_n   = 1'b1;
          sdo_n   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_n = HIGH;
          cnt_n   = p_lat;
          sck_n   = 1'b1;
          rx_sh_n = {rx_sh[6:0], spi_sdi};
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      HIGH: begin
        if (cnt_done) begin
          state_n   = LOW;
          cnt_n     = p_lat;
          sck_n     = 1'b0;
          bit_cnt_n = bit_cnt + 4'd1;
          // The last bit stays on spi_sdo through LOW and HOLD.
          if (bit_cnt != 4'd7) begin
            sdo_n   = tx_sh[6];
            tx_sh_n = {tx_sh[5:0], 1'b0};
          end
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      LOW: begin
        if (cnt_done) begin
          if (bit_cnt == 4'd8) begin
            state_n    = HOLD;
            rx_data_n  = rx_sh;
            rx_valid_n = 1'b1;
          end else begin
            state_n = HIGH;
            cnt_n   = p_lat;
            sck_n   = 1'b1;
            rx_sh_n = {rx_sh[6:0], spi_sdi};
          end
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      END: begin
        if (cnt_done) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Randomised bench for spi_master_byte: a timeline model derived from the byte
// timing rules is compared against the SPI pins and handshake on every cycle.
module tb_spi_master_byte;
  logic       core_clk = 1'b0;
  logic       core_rst = 1'b1;
  logic       enable   = 1'b0;
  logic [7:0] prescale = 8'd0;
  logic       cs_hold  = 1'b0;
  logic       busy, spi_sck, spi_csb, spi_sdo, spi_sdoenb, spi_sdi;
  logic [1:0] sdi_sel  = 2'd0;
  logic       sdi_drv  = 1'b0;
  logic       sdi_rand = 1'b0;
  logic       fl_out   = 1'b0;
  int         total = 0, bad = 0, ncyc = 0;

  spi_master_byte_if tif();

  spi_master_byte #(.DIV_W(8)) dut (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .enable    (enable),
    .prescale  (prescale),
    .cs_hold   (cs_hold),
    .busy      (busy),
    .spi_sck   (spi_sck),
    .spi_csb   (spi_csb),
    .spi_sdo   (spi_sdo),
    .spi_sdoenb(spi_sdoenb),
    .spi_sdi   (spi_sdi),
    .host      (tif)
  );

  always #5 core_clk = ~core_clk;

  // sdi source: 0 loopback, 1 bench-driven bit, 2 flash model
  assign spi_sdi = (sdi_sel == 2'd0) ? spi_sdo : (sdi_sel == 2'd1) ? sdi_drv : fl_out;

  always @(posedge core_clk) begin
    #2;
    if (sdi_rand) sdi_drv = 1'($urandom_range(0, 1));
  end

  // Small flash with READ (0x03) and a 16-bit address; data follows the third byte.
  int         fl_bits = 0;
  logic [23:0] fl_shift = '0;
  logic [7:0]  fl_byte  = '0;

  function automatic logic [7:0] flash_mem(input logic [15:0] a);
    return (a == 16'h0000) ? 8'h5E : (a[7:0] ^ 8'hA5);
  endfunction

  always @(posedge spi_sck or posedge spi_csb) begin
    if (spi_csb) fl_bits = 0;
    else begin
      fl_shift = {fl_shift[22:0], spi_sdo};
      fl_bits++;
      if (fl_bits == 24)
        fl_byte = (fl_shift[23:16] == 8'h03) ? flash_mem(fl_shift[15:0]) : 8'h00;
    end
  end

  always @(negedge spi_sck or posedge spi_csb) begin
    if (spi_csb) fl_out = 1'b0;
    else if (fl_bits >= 24 && fl_bits < 32) fl_out = fl_byte[31 - fl_bits];
    else fl_out = 1'b0;
  end

  // Reference model: bytes are described by accept edge t0 and period P;
  // outputs after edge t0+k follow from k/P alone.
  typedef enum {M_IDLE, M_BYTE, M_HOLD, M_END} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_edge = 0, m_t0 = 0, m_p = 1, m_t_end = 0, k = 0, ph = 0, j = 0;
  logic [7:0] m_tx = '0, m_rxsh = '0, m_rx = '0;
  logic       m_pulse = 1'b0, exp_csb = 1'b1, exp_sck = 1'b0, exp_sdo = 1'b0, sdi_now = 1'b0;

  always @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      m_mode = M_IDLE; m_rx = 8'h00; m_pulse = 1'b0;
      exp_csb = 1'b1; exp_sck = 1'b0; exp_sdo = 1'b0;
    end else begin
      sdi_now = (sdi_sel == 2'd0) ? exp_sdo : spi_sdi;
      m_edge++;
      m_pulse = 1'b0;
      case (m_mode)
        M_BYTE: begin
          k = m_edge - m_t0;
          if (k < 16 * m_p && k % m_p == 0 && (k / m_p) % 2 == 1) m_rxsh = {m_rxsh[6:0], sdi_now};
          if (k == 17 * m_p) begin m_mode = M_HOLD; m_rx = m_rxsh; m_pulse = 1'b1; end
        end
        M_IDLE, M_HOLD: begin
          if (enable && tif.tx_valid) begin
            m_mode = M_BYTE; m_t0 = m_edge; m_p = int'(prescale) + 1; m_tx = tif.tx_data; m_rxsh = '0;
          end else if (m_mode == M_HOLD && (!cs_hold || !enable)) begin
            m_mode = M_END; m_t_end = m_edge + m_p;
          end
        end
        M_END: if (m_edge == m_t_end) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      exp_csb = !(m_mode == M_BYTE || m_mode == M_HOLD);
      exp_sck = 1'b0;
      exp_sdo = 1'b0;
      if (m_mode == M_BYTE) begin
        k  = m_edge - m_t0;
        ph = k / m_p;
        j  = (ph / 2 > 7) ? 7 : ph / 2;
        exp_sck = (k < 16 * m_p) && (ph % 2 == 1);
        exp_sdo = m_tx[7 - j];
      end else if (m_mode == M_HOLD) begin
        exp_sdo = m_tx[0];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  int         sck_hi, sck_rise, sdo_hi, csb_fall, rxv_n, csb_rise_t;
  int         rxv_t[32];
  logic [7:0] sdo_rise;
  logic       sck_prev = 1'b0, csb_prev = 1'b1;

  task automatic clear_mon();
    sck_hi = 0; sck_rise = 0; sdo_hi = 0; csb_fall = 0; rxv_n = 0; csb_rise_t = 0; sdo_rise = '0;
  endtask

  always @(negedge core_clk) begin
    ncyc++;
    if (!core_rst) begin
      checkOutput("csb", spi_csb, exp_csb);
      checkOutput("sdoenb", spi_sdoenb, exp_csb);
      checkOutput("sck", spi_sck, exp_sck);
      checkOutput("sdo", spi_sdo, exp_sdo);
      checkOutput("rx_valid", tif.rx_valid, m_pulse);
      checkOutput("rx_data", tif.rx_data, m_rx);
      checkOutput("busy", busy, m_mode != M_IDLE);
      checkOutput("tx_ready", tif.tx_ready, enable && (m_mode == M_IDLE || m_mode == M_HOLD));
    end
    if (spi_sck === 1'b1) sck_hi++;
    if (spi_sck === 1'b1 && sck_prev === 1'b0) begin sck_rise++; sdo_rise = {sdo_rise[6:0], spi_sdo}; end
    if (spi_sdo === 1'b1) sdo_hi++;
    if (spi_csb === 1'b0 && csb_prev === 1'b1) csb_fall++;
    if (spi_csb === 1'b1 && csb_prev === 1'b0) csb_rise_t = ncyc;
    if (tif.rx_valid === 1'b1) begin
      if (rxv_n < 32) rxv_t[rxv_n] = ncyc;
      rxv_n++;
    end
    sck_prev = spi_sck;
    csb_prev = spi_csb;
  end

  // Returns #1 after the accepting edge; acc is the negedge count at that point.
  task automatic applyStimulus(input logic [7:0] d, input int presc, input logic hold, output int acc);
    bit ok;
    ok = 0;
    acc = 0;
    tif.tx_data = d; prescale = presc[7:0]; cs_hold = hold; tif.tx_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge core_clk);
      if (tif.tx_ready === 1'b1) ok = 1;
    end
    if (ok) begin @(posedge core_clk); #1; acc = ncyc; end
    tif.tx_valid = 1'b0;
    checkOutput("accept_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, d, p, h;
    tif.tx_data = 8'h00; tif.tx_valid = 1'b0;
    clear_mon();
    repeat (3) @(posedge core_clk);
    #1;
    checkOutput("rst_csb", spi_csb, 1);
    checkOutput("rst_sck", spi_sck, 0);
    checkOutput("rst_sdoenb", spi_sdoenb, 1);
    checkOutput("rst_sdo", spi_sdo, 0);
    checkOutput("rst_rx_valid", tif.rx_valid, 0);
    checkOutput("rst_rx_data", tif.rx_data, 8'h00);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready_en0", tif.tx_ready, 0);
    enable = 1'b1;
    #1;
    checkOutput("rst_ready_en1", tif.tx_ready, 1);
    @(posedge core_clk); #1;
    core_rst = 1'b0;
    repeat (2) @(posedge core_clk); #1;

    // Loopback 0xA5 at P=1
    sdi_sel = 2'd0; clear_mon();
    applyStimulus(8'hA5, 0, 1'b0, acc);
    repeat (25) @(posedge core_clk); #1;
    checkOutput("lb_sck_pulses", sck_rise, 8);
    checkOutput("lb_sck_high_cycles", sck_hi, 8);
    checkOutput("lb_sdo_pattern", sdo_rise, 8'hA5);
    checkOutput("lb_rx_latency", rxv_t[0] - acc - 1, 17);
    checkOutput("lb_rx_data", tif.rx_data, 8'hA5);
    checkOutput("lb_csb_rise", csb_rise_t - acc - 1, 18);

    // sdi held high, P=4, send 0x00
    sdi_sel = 2'd1; sdi_drv = 1'b1; clear_mon();
    applyStimulus(8'h00, 3, 1'b0, acc);
    repeat (80) @(posedge core_clk); #1;
    checkOutput("p4_sck_high_cycles", sck_hi, 32);
    checkOutput("p4_sck_pulses", sck_rise, 8);
    checkOutput("p4_sdo_high", sdo_hi, 0);
    checkOutput("p4_rx_latency", rxv_t[0] - acc - 1, 68);
    checkOutput("p4_rx_data", tif.rx_data, 8'hFF);

    // READ stream against the flash model with chip select held
    sdi_sel = 2'd2; clear_mon();
    applyStimulus(8'h03, 0, 1'b1, acc);
    applyStimulus(8'h00, 0, 1'b1, acc);
    applyStimulus(8'h00, 0, 1'b1, acc);
    applyStimulus(8'h00, 0, 1'b1, acc);
    cs_hold = 1'b0;
    repeat (30) @(posedge core_clk); #1;
    checkOutput("fl_csb_windows", csb_fall, 1);
    checkOutput("fl_sck_pulses", sck_rise, 32);
    checkOutput("fl_rx_pulses", rxv_n, 4);
    for (int i = 0; i < 3; i++) checkOutput("fl_rx_spacing", rxv_t[i + 1] - rxv_t[i], 18);
    checkOutput("fl_rx_data", tif.rx_data, 8'h5E);

    // Reset pulse mid-transfer, then a clean loopback byte
    sdi_sel = 2'd0; clear_mon();
    applyStimulus(8'hC3, 0, 1'b0, acc);
    repeat (9) @(posedge core_clk);
    #1 core_rst = 1'b1;
    #1;
    checkOutput("mid_rst_csb", spi_csb, 1);
    checkOutput("mid_rst_sck", spi_sck, 0);
    checkOutput("mid_rst_busy", busy, 0);
    @(posedge core_clk); #1;
    core_rst = 1'b0;
    repeat (20) @(posedge core_clk); #1;
    checkOutput("mid_rst_no_rx", rxv_n, 0);
    applyStimulus(8'h3C, 0, 1'b0, acc);
    repeat (22) @(posedge core_clk); #1;
    checkOutput("post_rst_rx_data", tif.rx_data, 8'h3C);
    checkOutput("post_rst_rx_pulses", rxv_n, 1);

    // enable dropped during a byte with chip select held
    clear_mon();
    applyStimulus(8'h96, 0, 1'b1, acc);
    repeat (5) @(posedge core_clk);
    #1 enable = 1'b0;
    repeat (25) @(posedge core_clk); #1;
    checkOutput("en_drop_rx_pulses", rxv_n, 1);
    checkOutput("en_drop_rx_data", tif.rx_data, 8'h96);
    checkOutput("en_drop_csb_rise", csb_rise_t - acc - 1, 18);
    checkOutput("en_drop_csb", spi_csb, 1);
    checkOutput("en_drop_ready", tif.tx_ready, 0);
    checkOutput("en_drop_busy", busy, 0);
    enable = 1'b1; cs_hold = 1'b0;
    @(posedge core_clk); #1;

    // Random bytes, prescales, hold choices, idle gaps and sdi bits
    sdi_sel = 2'd1; sdi_rand = 1'b1; clear_mon();
    for (int n = 0; n < 24; n++) begin
      d = int'($urandom_range(0, 255));
      p = int'($urandom_range(0, 3));
      h = int'($urandom_range(0, 1));
      applyStimulus(d[7:0], p, h[0], acc);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(17, 90)) @(posedge core_clk);
        #1;
      end
    end
    cs_hold = 1'b0;
    repeat (120) @(posedge core_clk); #1;
    checkOutput("rand_rx_pulses", rxv_n, 24);
    checkOutput("rand_idle_csb", spi_csb, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
